// File: rtl/translation_request_engine.sv
// Round-robin multi-slot TLB-miss servicer: AXI-Lite vaddr read, QDMA H2C bypass descriptor, optional replay write.
// Optional feature macro: TRANS_REQ_PAGE_ALIGN_EN (forces raddr[11:0] to zero).
module translation_request_engine #(
    parameter int          ADDR_WIDTH     = 64,
    parameter int          DATA_WIDTH     = 64,
    parameter int          NUM_SLOTS      = 4,
    parameter logic [63:0] MISS_BASE_ADDR = 64'h0000_0000_0100_0020,
    parameter int          SLOT_STRIDE    = 8,
    parameter logic [63:0] REPLAY_ADDR    = 64'h0000_0000_0100_0000,
    parameter logic [63:0] REPLAY_DATA    = 64'h0000_0000_0000_0100,
    parameter int          VADDR_BITS     = 48,
    parameter logic [15:0] DESCR_LEN      = 16'd8,
    parameter logic [10:0] DESCR_QID      = 11'd1,
    parameter int          TIMEOUT_CYCLES = 1024,
    localparam int         SW             = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    ats,
    input  logic [NUM_SLOTS-1:0]    tlb_miss,
    input  logic [NUM_SLOTS-1:0]    cache_overlap,
    output logic                    m_h2c_byp_in_st_vld,
    input  logic                    m_h2c_byp_in_st_rdy,
    output logic [63:0]             m_h2c_byp_in_raddr,
    output logic [15:0]             m_h2c_byp_in_cidx,
    output logic [1:0]              m_h2c_byp_in_at,
    output logic                    m_h2c_byp_in_sop,
    output logic                    m_h2c_byp_in_eop,
    output logic                    m_h2c_byp_in_error,
    output logic [7:0]              m_h2c_byp_in_func,
    output logic                    m_h2c_byp_in_mrkr_req,
    output logic                    m_h2c_byp_in_no_dma,
    output logic [2:0]              m_h2c_byp_in_port_id,
    output logic                    m_h2c_byp_in_sdi,
    output logic [15:0]             m_h2c_byp_in_len,
    output logic [10:0]             m_h2c_byp_in_qid,
    output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]              m00_axi_awprot,
    output logic                    m00_axi_awvalid,
    input  logic                    m00_axi_awready,
    output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                    m00_axi_wvalid,
    input  logic                    m00_axi_wready,
    input  logic [1:0]              m00_axi_bresp,
    input  logic                    m00_axi_bvalid,
    output logic                    m00_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]              m00_axi_arprot,
    output logic                    m00_axi_arvalid,
    input  logic                    m00_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]              m00_axi_rresp,
    input  logic                    m00_axi_rvalid,
    output logic                    m00_axi_rready,
    output logic                    busy,
    output logic [SW-1:0]           cur_slot,
    output logic [15:0]             err_count,
    output logic                    timeout_flag
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_DESCR = 3'd3,
        S_WR    = 3'd4,
        S_B     = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                 r_state;
    logic [SW-1:0]          r_cur_slot;
    logic [SW-1:0]          r_last;
    logic [NUM_SLOTS-1:0]   r_served;
    logic [NUM_SLOTS-1:0]   r_overlap_q;
    logic                   r_ovl;
    logic                   r_arvalid, r_rready, r_st_vld, r_awvalid, r_wvalid, r_bready;
    logic [ADDR_WIDTH-1:0]  r_araddr, r_awaddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [63:0]            r_raddr;
    logic [15:0]            r_err;
    logic [31:0]            r_tmo_cnt;
    logic                   r_timeout;

    logic [NUM_SLOTS-1:0]   w_elig;
    logic                   w_found;
    logic [SW-1:0]          w_pick;
    logic [63:0]            w_vaddr;
    logic                   w_unused;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_elig   = tlb_miss & ~r_served;
    assign w_unused = ^m00_axi_rdata;

    // Round-robin pick: descending scan so the nearest slot after r_last wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            int idx;
            idx     = int'(r_last) + k;
            idx     = (idx >= NUM_SLOTS) ? idx - NUM_SLOTS : idx;
            w_found = w_found | w_elig[idx];
            w_pick  = w_elig[idx] ? SW'(idx) : w_pick;
        end
    end

    // Translation address taken from the read data, zero-extended above VADDR_BITS.
    always_comb begin
        w_vaddr = 64'(m00_axi_rdata[VADDR_BITS-1:0]);
`ifdef TRANS_REQ_PAGE_ALIGN_EN
        w_vaddr[11:0] = 12'h000;
`else
        w_vaddr[11:0] = m00_axi_rdata[11:0];
`endif
    end

    // Sequencer, served tracking, error counter and response timeout.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_cur_slot  <= '0;
            r_last      <= SW'(NUM_SLOTS - 1);
            r_served    <= '0;
            r_overlap_q <= '0;
            r_ovl       <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_st_vld    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_raddr     <= 64'd0;
            r_err       <= 16'd0;
            r_tmo_cnt   <= 32'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_overlap_q <= cache_overlap;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!tlb_miss[i]) begin
                    r_served[i] <= 1'b0;
                end else if (r_state == S_DONE && int'(r_cur_slot) == i) begin
                    r_served[i] <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (ats && w_found) begin
                        r_cur_slot <= w_pick;
                        r_araddr   <= ADDR_WIDTH'(MISS_BASE_ADDR + 64'(w_pick) * 64'(SLOT_STRIDE));
                        r_arvalid  <= 1'b1;
                        r_state    <= S_AR;
                    end
                end
                S_AR: begin
                    if (m00_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_tmo_cnt <= 32'd0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (m00_axi_rvalid) begin
                        r_rready <= 1'b0;
                        r_ovl    <= r_overlap_q[r_cur_slot];
                        if (m00_axi_rresp != 2'b00) begin
                            r_err   <= sat_inc(r_err);
                            r_state <= S_DONE;
                        end else begin
                            r_raddr  <= w_vaddr;
                            r_st_vld <= 1'b1;
                            r_state  <= S_DESCR;
                        end
                    end
                end
                S_DESCR: begin
                    if (m_h2c_byp_in_st_rdy) begin
                        r_st_vld <= 1'b0;
                        if (r_ovl) begin
                            r_awaddr  <= ADDR_WIDTH'(REPLAY_ADDR);
                            r_wdata   <= DATA_WIDTH'(REPLAY_DATA | 64'(r_cur_slot));
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WR: begin
                    // Each channel retires on its own handshake; move on once neither is still pending.
                    if (r_awvalid && m00_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m00_axi_wready) r_wvalid <= 1'b0;
                    if (!(r_awvalid && !m00_axi_awready) && !(r_wvalid && !m00_axi_wready)) begin
                        r_bready  <= 1'b1;
                        r_tmo_cnt <= 32'd0;
                        r_state   <= S_B;
                    end
                end
                S_B: begin
                    if (m00_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (m00_axi_bresp != 2'b00) r_err <= sat_inc(r_err);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last  <= r_cur_slot;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if ((r_state == S_R && !m00_axi_rvalid) || (r_state == S_B && !m00_axi_bvalid)) begin
                if (r_tmo_cnt < 32'(TIMEOUT_CYCLES)) r_tmo_cnt <= r_tmo_cnt + 32'd1;
                if (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
            end
        end
    end

    assign m_h2c_byp_in_st_vld   = r_st_vld;
    assign m_h2c_byp_in_raddr    = r_raddr;
    assign m_h2c_byp_in_cidx     = 16'd1;
    assign m_h2c_byp_in_at       = 2'd1;
    assign m_h2c_byp_in_sop      = 1'b1;
    assign m_h2c_byp_in_eop      = 1'b1;
    assign m_h2c_byp_in_error    = 1'b0;
    assign m_h2c_byp_in_func     = 8'd0;
    assign m_h2c_byp_in_mrkr_req = 1'b0;
    assign m_h2c_byp_in_no_dma   = 1'b0;
    assign m_h2c_byp_in_port_id  = 3'd2;
    assign m_h2c_byp_in_sdi      = 1'b0;
    assign m_h2c_byp_in_len      = DESCR_LEN;
    assign m_h2c_byp_in_qid      = DESCR_QID;
    assign m00_axi_awaddr        = r_awaddr;
    assign m00_axi_awprot        = 3'd0;
    assign m00_axi_awvalid       = r_awvalid;
    assign m00_axi_wdata         = r_wdata;
    assign m00_axi_wstrb         = '1;
    assign m00_axi_wvalid        = r_wvalid;
    assign m00_axi_bready        = r_bready;
    assign m00_axi_araddr        = r_araddr;
    assign m00_axi_arprot        = 3'd0;
    assign m00_axi_arvalid       = r_arvalid;
    assign m00_axi_rready        = r_rready;
    assign busy                  = (r_state != S_IDLE);
    assign cur_slot              = r_cur_slot;
    assign err_count             = r_err;
    assign timeout_flag          = r_timeout;

endmodule
